nonce_reply_framer: RTL and testbench
=====================================

Name: nonce_reply_framer

Overview:
- Downstream of the mining core, upstream of the UART transmitter inside the miner top level.
- Queues golden nonces reported by the hashing core and serialises each one as an 8-byte MSG_NONCE frame onto a byte-stream handshake feeding the UART TX.
- Frame format is 08 00 00 03 N3 N2 N1 N0: length 8 (includes header), two zero bytes, type 0x03, then the nonce MSB first. No CRC.

Parameters:
- FIFO_LOG2, 2, log2 of nonce queue depth (default depth 4).
- MSG_NONCE_TYPE, 8'h03, message type byte.
- MSG_NONCE_LEN, 8'd8, length byte.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- nonce_valid  in  1  one-cycle strobe: golden nonce found.
- nonce  in  32  golden nonce value.
- flush  in  1  one-cycle strobe: new job accepted; discard queued nonces.
- tx_data  out  8  byte to UART TX.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART TX accepts byte this cycle.
- frame_active  out  1  high from first byte offered until last byte accepted; the top-level arbiter must not interleave other replies.
- queue_full  out  1  FIFO full.
- drop_count  out  8  saturating count of nonces dropped on full.

Behaviour:
- Reset: tx_data=0, tx_valid=0, frame_active=0, queue_full=0, drop_count=0, FIFO empty, FSM=IDLE. Reset mid-frame abandons the frame immediately; tx_valid drops the next cycle.
- Byte handshake: a transfer occurs on tx_valid && tx_ready at the CLK edge. While tx_valid=1 and tx_ready=0, tx_data holds stable. tx_valid never retracts without a transfer, except on RST.
- FIFO: circular, FIFO_LOG2-bit pointers with an extra wrap bit. Write on nonce_valid when not full. Read (pop) when IDLE loads a frame.
  - Full: the incoming nonce is dropped and drop_count increments, saturating at 255.
  - Push while full in the same cycle as a pop: the push is still dropped. Full status is evaluated before the pop.
- FSM states:
  - IDLE: if FIFO non-empty, pop into a 32-bit shadow register, set byte index 0, go to SEND. Latency from nonce_valid into an empty FIFO to tx_valid=1 is 2 cycles: cycle 1 write, cycle 2 pop/load, tx_valid registered high after that edge.
  - SEND: present byte[idx]. On transfer, idx++. When idx=7 transfers, go to IDLE, or back-to-back into the next frame if the FIFO is non-empty. Back-to-back frames have no idle cycle: tx_valid stays high.
  - Byte order: LEN, 00, 00, TYPE, nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0].
- frame_active: 1 in SEND, 0 in IDLE.
- flush:
  - Clears FIFO pointers and queue_full next cycle.
  - An in-progress frame completes unmodified; the shadow register is unaffected.
  - flush and nonce_valid in the same cycle: flush wins and the nonce is discarded, not counted as dropped.
  - drop_count is not cleared by flush.

Optional Feature:
- Macro NONCE_DEDUP_EN.
- Defined: the block keeps last_pushed (32b) and last_valid (1b). A nonce_valid whose value equals last_pushed while last_valid=1 is silently discarded; it is not counted in drop_count. last_valid clears on RST and flush.
- Undefined: every nonce_valid is queued; no comparison register exists.

Decomposition:
- Shared package / header: MSG_NONCE_TYPE (03), MSG_INVALID_TYPE (01), MSG_INFO/PUSH_JOB type codes (00/02), MSG_NONCE_LEN (8), PONG byte (01). These are the same constants used by the command parser.
- One natural sub-module: nonce_fifo, a synchronous FIFO with full/empty flags, parameterised width and depth. The framer FSM stays in this block.

Test Plan:
- Single nonce 0x1DAC2B7C, tx_ready always 1 -> bytes 08 00 00 03 1D AC 2B 7C on consecutive cycles; frame_active high for exactly 8 cycles.
- Same nonce with tx_ready toggling 1010… -> identical byte sequence; tx_data stable during every stalled cycle.
- 6 back-to-back nonces 0x00000001..0x00000006 with tx_ready=0 -> queue_full after 4 (or 5 including the shadow); drop_count counts the remainder. On release, frames arrive in push order with no gap between frames.
- flush asserted during byte 3 of a frame with 2 nonces queued -> current frame completes; no further frames; queue_full=0.
- flush and nonce_valid (0xDEADBEEF) in the same cycle -> no frame emitted, drop_count unchanged.
- NONCE_DEDUP_EN: push 0xCAFEF00D twice, then 0x12345678 -> 2 frames only. Repeat after flush -> 0xCAFEF00D is framed again.

Source files
------------

// File: rtl/nonce_reply_framer_pkg.sv
// ---------------------------------------------------------------------------
// nonce_reply_framer_pkg
//   Shared constants and types for the miner reply path. These are the same
//   message-type codes and lengths the command parser uses, so the framer and
//   the parser always agree on the wire format.
//
//   Contents:
//     MSG_INFO_TYPE / MSG_INVALID_TYPE / MSG_PUSH_JOB_TYPE / MSG_NONCE_TYPE
//                       message type codes 00 / 01 / 02 / 03
//     MSG_NONCE_LEN     length byte of a nonce frame (8, header included)
//     PONG_BYTE         single-byte ping reply
//     FRAME_BYTES       number of bytes in a nonce frame
//     framer_state_t    framer FSM states
//     frame_byte()      selects one byte of a nonce frame by index
// ---------------------------------------------------------------------------
package nonce_reply_framer_pkg;

   localparam logic [7:0] MSG_INFO_TYPE     = 8'h00;
   localparam logic [7:0] MSG_INVALID_TYPE  = 8'h01;
   localparam logic [7:0] MSG_PUSH_JOB_TYPE = 8'h02;
   localparam logic [7:0] MSG_NONCE_TYPE    = 8'h03;
   localparam logic [7:0] MSG_NONCE_LEN     = 8'd8;
   localparam logic [7:0] PONG_BYTE         = 8'h01;

   localparam int FRAME_BYTES = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } framer_state_t;

   // Frame layout: LEN, 00, 00, TYPE, then the nonce most significant byte
   // first. There is no trailing checksum.
   function automatic logic [7:0] frame_byte(
      input logic [31:0] value,
      input logic [2:0]  idx,
      input logic [7:0]  len_byte,
      input logic [7:0]  type_byte
   );
      logic [7:0] result;
      result = 8'h00;
      case (idx)
         3'd0:    result = len_byte;
         3'd1:    result = 8'h00;
         3'd2:    result = 8'h00;
         3'd3:    result = type_byte;
         3'd4:    result = value[31:24];
         3'd5:    result = value[23:16];
         3'd6:    result = value[15:8];
         3'd7:    result = value[7:0];
         default: result = 8'h00;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/nonce_reply_framer_nonce_fifo.sv
// ---------------------------------------------------------------------------
// nonce_fifo
//   Synchronous circular FIFO with full/empty flags. Pointers carry one extra
//   wrap bit so full and empty can be told apart without a counter. The head
//   entry is visible on rd_data whenever the FIFO is non-empty, and rd_en
//   pops it at the clock edge.
//
//   Ports:
//     clk       system clock
//     rst       synchronous active-high reset (empties the FIFO)
//     clear     synchronous discard of all entries
//     wr_en     push wr_data (ignored when full or clearing)
//     wr_data   entry to push
//     rd_en     pop the head entry (ignored when empty)
//     rd_data   head entry
//     full      FIFO holds 2**LOG2_DEPTH entries
//     empty     FIFO holds no entries
// ---------------------------------------------------------------------------
module nonce_fifo #(
   parameter int WIDTH      = 32,
   parameter int LOG2_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   import nonce_reply_framer_pkg::*;

   localparam int DEPTH = 1 << LOG2_DEPTH;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [LOG2_DEPTH:0] wr_ptr;
   logic [LOG2_DEPTH:0] rd_ptr;
   logic                wr_fire;
   logic                rd_fire;

   // Same index with opposite wrap bits means the writer is a full lap ahead.
   assign full    = (wr_ptr[LOG2_DEPTH] != rd_ptr[LOG2_DEPTH]) &&
                    (wr_ptr[LOG2_DEPTH-1:0] == rd_ptr[LOG2_DEPTH-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign wr_fire = wr_en && !full && !clear;
   assign rd_fire = rd_en && !empty && !clear;
   assign rd_data = mem[rd_ptr[LOG2_DEPTH-1:0]];

   // Pointer update. Full is judged on the pre-edge pointers, so a push
   // arriving while full is refused even if a pop happens in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Storage needs no reset; the pointers decide which entries are live.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_ptr[LOG2_DEPTH-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/nonce_reply_framer.sv
// ---------------------------------------------------------------------------
// nonce_reply_framer
//   Queues golden nonces from the hashing core and serialises each one as an
//   8-byte MSG_NONCE frame (08 00 00 03 N3 N2 N1 N0) onto a valid/ready byte
//   stream feeding the UART transmitter. Consecutive frames are sent with no
//   idle cycle between them.
//
//   Ports:
//     CLK           system clock
//     RST           synchronous active-high reset
//     nonce_valid   one-cycle strobe: golden nonce found
//     nonce         golden nonce value
//     flush         one-cycle strobe: new job, discard queued nonces
//     tx_data       byte to UART TX
//     tx_valid      tx_data is valid
//     tx_ready      UART TX accepts the byte this cycle
//     frame_active  a frame is in flight; other replies must not interleave
//     queue_full    nonce queue is full
//     drop_count    saturating count of nonces dropped because of a full queue
//
//   Build option:
//     NONCE_DEDUP_EN  when defined, a nonce equal to the last queued one is
//                     silently discarded (history cleared by RST and flush).
// ---------------------------------------------------------------------------
module nonce_reply_framer #(
   parameter int         FIFO_LOG2      = 2,
   parameter logic [7:0] MSG_NONCE_TYPE = nonce_reply_framer_pkg::MSG_NONCE_TYPE,
   parameter logic [7:0] MSG_NONCE_LEN  = nonce_reply_framer_pkg::MSG_NONCE_LEN
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        nonce_valid,
   input  logic [31:0] nonce,
   input  logic        flush,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        frame_active,
   output logic        queue_full,
   output logic [7:0]  drop_count
);
   import nonce_reply_framer_pkg::*;

   framer_state_t state;
   framer_state_t next_state;
   logic [2:0]    byte_idx;
   logic [2:0]    next_idx;
   logic [31:0]   shadow;
   logic          load;
   logic          pop;

   logic [31:0]   fifo_rd_data;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push_req;
   logic          dup_hit;
   logic [7:0]    drop_q;

   // A flush discards the nonce arriving in the same cycle, and a repeated
   // nonce is never even offered to the queue.
   assign push_req = nonce_valid && !flush && !dup_hit;

   nonce_fifo #(
      .WIDTH      (32),
      .LOG2_DEPTH (FIFO_LOG2)
   ) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .clear   (flush),
      .wr_en   (push_req),
      .wr_data (nonce),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

`ifdef NONCE_DEDUP_EN
   logic [31:0] last_pushed;
   logic        last_valid;

   assign dup_hit = last_valid && (nonce == last_pushed);

   // Remember the last nonce actually written to the queue; refused pushes
   // (queue full) do not update the history.
   always_ff @(posedge CLK) begin
      if (RST) begin
         last_pushed <= '0;
         last_valid  <= 1'b0;
      end else if (flush) begin
         last_valid  <= 1'b0;
      end else if (push_req && !fifo_full) begin
         last_pushed <= nonce;
         last_valid  <= 1'b1;
      end
   end
`else
   assign dup_hit = 1'b0;
`endif

   // Count pushes refused because the queue was full, sticking at 255.
   always_ff @(posedge CLK) begin
      if (RST) begin
         drop_q <= 8'h00;
      end else if (push_req && fifo_full && (drop_q != 8'hFF)) begin
         drop_q <= drop_q + 8'h01;
      end
   end

   // State register: FSM state, byte index and the shadow copy of the nonce
   // being framed. The shadow is only replaced on a load, so a flush never
   // disturbs a frame already in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ST_IDLE;
         byte_idx <= 3'd0;
         shadow   <= '0;
      end else begin
         state    <= next_state;
         byte_idx <= next_idx;
         if (load) begin
            shadow <= fifo_rd_data;
         end
      end
   end

   // Next-state logic. A new frame is loaded either from IDLE or straight
   // off the last byte's transfer, which keeps back-to-back frames gapless.
   // Loading is suppressed during a flush because the queue is being dropped.
   always_comb begin
      next_state = state;
      next_idx   = byte_idx;
      load       = 1'b0;
      pop        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty && !flush) begin
               load       = 1'b1;
               pop        = 1'b1;
               next_idx   = 3'd0;
               next_state = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_ready) begin
               if (byte_idx == 3'd7) begin
                  next_idx = 3'd0;
                  if (!fifo_empty && !flush) begin
                     load       = 1'b1;
                     pop        = 1'b1;
                     next_state = ST_SEND;
                  end else begin
                     next_state = ST_IDLE;
                  end
               end else begin
                  next_idx = byte_idx + 3'd1;
               end
            end
         end
         default: begin
            next_state = ST_IDLE;
            next_idx   = 3'd0;
         end
      endcase
   end

   // Outputs are decoded from registered state only, so tx_data holds
   // steady across stalled cycles and reads zero outside a frame.
   always_comb begin
      tx_valid     = (state == ST_SEND);
      frame_active = (state == ST_SEND);
      tx_data      = 8'h00;
      if (state == ST_SEND) begin
         tx_data = frame_byte(shadow, byte_idx, MSG_NONCE_LEN, MSG_NONCE_TYPE);
      end
      queue_full = fifo_full;
      drop_count = drop_q;
   end

endmodule

// File: tb/tb_nonce_reply_framer.sv
// ---------------------------------------------------------------------------
// tb_nonce_reply_framer
//   Self-checking bench for nonce_reply_framer. A queue-based reference model
//   (pending nonces + bytes left of the current frame) predicts every output
//   each cycle. Inputs change just after the falling edge and outputs are
//   checked on the falling edge, clear of the rising edge the DUT uses.
//   Build with NONCE_DEDUP_EN defined to also exercise duplicate filtering.
// ---------------------------------------------------------------------------
module tb_nonce_reply_framer;

   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        nonce_valid;
   logic [31:0] nonce;
   logic        flush;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        frame_active;
   logic        queue_full;
   logic [7:0]  drop_count;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [31:0] mq[$];
   logic [7:0]  cur[$];
   int          m_drops;
   logic [31:0] m_last;
   logic        m_last_valid;

   always #5 CLK = ~CLK;

   nonce_reply_framer dut (
      .CLK          (CLK),
      .RST          (RST),
      .nonce_valid  (nonce_valid),
      .nonce        (nonce),
      .flush        (flush),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .frame_active (frame_active),
      .queue_full   (queue_full),
      .drop_count   (drop_count)
   );

   function automatic logic [18:0] exp_vec();
      logic       v;
      logic [7:0] d;
      v = (cur.size() > 0);
      d = v ? cur[0] : 8'h00;
      return {v, d, v, (mq.size() == DEPTH), m_drops[7:0]};
   endfunction

   function automatic logic [18:0] dut_vec();
      return {tx_valid, tx_data, frame_active, queue_full, drop_count};
   endfunction

   // Apply one cycle of inputs to the DUT and advance the model by the same
   // clock edge.
   task automatic drive(input logic rst, input logic nv, input logic [31:0] n,
                        input logic fl, input logic rdy);
      logic        v;
      logic        xfer;
      logic        was_full;
      logic        ends;
      logic        dup;
      logic [31:0] h;
      RST         = rst;
      nonce_valid = nv;
      nonce       = n;
      flush       = fl;
      tx_ready    = rdy;
      if (rst) begin
         mq.delete();
         cur.delete();
         m_drops      = 0;
         m_last_valid = 1'b0;
         m_last       = '0;
         return;
      end
      v        = (cur.size() > 0);
      xfer     = v && rdy;
      was_full = (mq.size() == DEPTH);
      ends     = !v || (xfer && cur.size() == 1);
      dup      = 1'b0;
`ifdef NONCE_DEDUP_EN
      dup = m_last_valid && (n == m_last);
`endif
      if (xfer) void'(cur.pop_front());
      if (ends && mq.size() > 0 && !fl) begin
         h   = mq.pop_front();
         cur = {8'h08, 8'h00, 8'h00, 8'h03, h[31:24], h[23:16], h[15:8], h[7:0]};
      end
      if (fl) begin
         mq.delete();
         m_last_valid = 1'b0;
      end else if (nv && !dup) begin
         if (was_full) begin
            if (m_drops < 255) m_drops++;
         end else begin
            mq.push_back(n);
            m_last       = n;
            m_last_valid = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL reset c%0d observed=%h required=%h", c, dut_vec(), exp_vec());
         end
         drive(c < 1, 1'b0, 32'h0, 1'b0, 1'b0);
      end
   endtask

   task automatic test_single();
      int active_cycles = 0;
      drive(1'b0, 1'b1, 32'h1DAC2B7C, 1'b0, 1'b1);
      for (int c = 0; c < 14; c++) begin
         @(negedge CLK);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL single c%0d observed=%h required=%h", c, dut_vec(), exp_vec());
         end
         if (frame_active === 1'b1) active_cycles++;
         drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      end
      vectors++;
      if (active_cycles != 8) begin
         miscompares++;
         $display("[TB] FAIL single_active_len observed=%0d required=8", active_cycles);
      end
   endtask

   task automatic test_stall();
      drive(1'b0, 1'b1, 32'h1DAC2B7C, 1'b0, 1'b1);
      for (int c = 0; c < 22; c++) begin
         @(negedge CLK);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL stall c%0d observed=%h required=%h", c, dut_vec(), exp_vec());
         end
         drive(1'b0, 1'b0, 32'h0, 1'b0, (c % 2) == 0);
      end
   endtask

   task automatic test_overflow();
      for (int c = 0; c < 70; c++) begin
         @(negedge CLK);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL overflow c%0d observed=%h required=%h", c, dut_vec(), exp_vec());
         end
         drive(1'b0, c < 6, 32'(c + 1), 1'b0, c >= 14);
      end
   endtask

   task automatic test_flush_mid();
      logic [31:0] a;
      logic fl;
      a = $urandom;
      for (int c = 0; c < 28; c++) begin
         @(negedge CLK);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL flush_mid c%0d observed=%h required=%h", c, dut_vec(), exp_vec());
         end
         fl = (cur.size() == 5) && (mq.size() == 2);
         drive(1'b0, c < 3, a + 32'(c), fl, 1'b1);
      end
   endtask

   task automatic test_flush_with_push();
      for (int c = 0; c < 12; c++) begin
         @(negedge CLK);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL flush_push c%0d observed=%h required=%h", c, dut_vec(), exp_vec());
         end
         drive(1'b0, c == 0, 32'hDEADBEEF, c == 0, 1'b1);
      end
   endtask

   task automatic test_reset_midframe();
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL reset_mid c%0d observed=%h required=%h", c, dut_vec(), exp_vec());
         end
         drive(c == 5, c < 2, 32'h0BADF00D + 32'(c), 1'b0, 1'b1);
      end
   endtask

   task automatic test_drop_saturate();
      for (int c = 0; c < 270; c++) begin
         @(negedge CLK);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL saturate c%0d observed=%h required=%h", c, dut_vec(), exp_vec());
         end
         drive(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
      end
      @(negedge CLK);
      vectors++;
      if (drop_count !== 8'hFF) begin
         miscompares++;
         $display("[TB] FAIL saturate_final observed=%h required=ff", drop_count);
      end
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge CLK);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
   endtask

`ifdef NONCE_DEDUP_EN
   task automatic test_dedup();
      int xfers = 0;
      logic [31:0] pat [4];
      pat[0] = 32'hCAFEF00D;
      pat[1] = 32'hCAFEF00D;
      pat[2] = 32'h12345678;
      pat[3] = 32'h0;
      for (int c = 0; c < 50; c++) begin
         @(negedge CLK);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL dedup c%0d observed=%h required=%h", c, dut_vec(), exp_vec());
         end
         if (c < 30 && tx_valid === 1'b1) xfers++;
         if (c < 3)
            drive(1'b0, 1'b1, pat[c], 1'b0, 1'b1);
         else if (c == 30)
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         else if (c == 31)
            drive(1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
         else
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      end
      vectors++;
      if (xfers != 16) begin
         miscompares++;
         $display("[TB] FAIL dedup_bytes observed=%0d required=16", xfers);
      end
   endtask
`endif

   task automatic test_random();
      logic rst;
      logic nv;
      logic fl;
      logic rdy;
      logic [31:0] n;
      for (int c = 0; c < 400; c++) begin
         @(negedge CLK);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL random c%0d observed=%h required=%h", c, dut_vec(), exp_vec());
         end
         rst = (c < 360) && ($urandom_range(0, 199) == 0);
         nv  = (c < 360) && ($urandom_range(0, 99) < 35);
         fl  = (c < 360) && ($urandom_range(0, 99) < 3);
         rdy = (c >= 360) || ($urandom_range(0, 99) < 60);
         n   = 32'hA5A50000 + 32'($urandom_range(0, 3));
         drive(rst, nv, n, fl, rdy);
      end
   endtask

   initial begin
      $display("[TB] nonce_reply_framer bench starting");
      test_reset();
      test_single();
      test_stall();
      test_overflow();
      test_flush_mid();
      test_flush_with_push();
      test_reset_midframe();
      test_drop_saturate();
`ifdef NONCE_DEDUP_EN
      test_dedup();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
